// File: rtl/vga_timing_gen_pkg.sv
// ----------------------------------------------------------------------------
// vga_timing_gen_pkg
//   Shared constants and types for the 640x480@60 Hz VGA raster generator.
//   Holds the nominal horizontal/vertical timing, the sync polarity, the
//   12-bit colour type and the colour-bar lookup used by the optional test
//   pattern (VGA_TEST_PATTERN_EN).
// ----------------------------------------------------------------------------
package vga_timing_gen_pkg;

    // Horizontal timing, in pixels.
    localparam int H_DISPLAY = 640;
    localparam int H_FRONT   = 16;
    localparam int H_BACK    = 48;
    localparam int H_RETRACE = 96;
    localparam int H_TOTAL   = H_DISPLAY + H_FRONT + H_BACK + H_RETRACE;

    // Vertical timing, in lines.
    localparam int V_DISPLAY = 480;
    localparam int V_FRONT   = 10;
    localparam int V_BACK    = 33;
    localparam int V_RETRACE = 2;
    localparam int V_TOTAL   = V_DISPLAY + V_FRONT + V_BACK + V_RETRACE;

    // Scan coordinates are 10 bits; both totals stay below 1024.
    localparam int COORD_W = 10;

    // Both syncs are active low for this mode.
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef logic [11:0] rgb_t;
    localparam rgb_t RGB_BLACK = 12'h000;

    // Colour of each of the eight vertical test bars, left to right.
    function automatic rgb_t bar_colour(input logic [2:0] idx);
        rgb_t c;
        case (idx)
            3'd0:    c = 12'hf00;
            3'd1:    c = 12'h0f0;
            3'd2:    c = 12'h00f;
            3'd3:    c = 12'hff0;
            3'd4:    c = 12'h0ff;
            3'd5:    c = 12'hf0f;
            3'd6:    c = 12'hfff;
            default: c = 12'h000;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/vga_timing_gen_mod_m_counter.sv
// ----------------------------------------------------------------------------
// mod_m_counter
//   Free-running modulo-M counter with a count enable. Used for the pixel
//   divider and for the horizontal and vertical scan counters.
//
//   Ports
//     clk          system clock
//     reset        synchronous, active-high reset (count returns to 0)
//     en_i         advance the count on this clock
//     count_o      current count, 0..M-1
//     count_next_o value the count takes on the next clock (excluding reset)
//     max_tick_o   high while count_o == M-1 (independent of en_i)
//
//   M must be >= 2.
// ----------------------------------------------------------------------------
module mod_m_counter
    import vga_timing_gen_pkg::*;
#(
    parameter int M = 4,
    parameter int W = $clog2(M)
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en_i,
    output logic [W-1:0] count_o,
    output logic [W-1:0] count_next_o,
    output logic         max_tick_o
);

    localparam logic [W-1:0] LAST = W'(M - 1);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        count_d = count_q;
        if (en_i) begin
            count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its inputs from before the edge, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o      = count_q;
    assign count_next_o = count_d;
    assign max_tick_o   = (count_q == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// ----------------------------------------------------------------------------
// vga_timing_gen
//   640x480@60 Hz VGA raster generator. Divides the system clock down to the
//   pixel rate, scans pix_x/pix_y across the full raster, generates the
//   active-low syncs and registers the colour returned by the graphics layer
//   onto the pin outputs (blanked outside the visible area).
//
//   Ports
//     clk          system clock
//     reset        synchronous, active-high reset
//     pattern_sel  (VGA_TEST_PATTERN_EN only) show eight colour bars
//     rgb_in       colour for the current pix_x/pix_y from the graphics mux
//     p_tick       one-clk pulse per pixel period
//     pix_x        current column, 0..H_TOTAL-1
//     pix_y        current line, 0..V_TOTAL-1
//     video_on     high inside the visible H_DISPLAY x V_DISPLAY area
//     hsync        horizontal sync, active low
//     vsync        vertical sync, active low
//     frame_tick   one-clk pulse on the last pixel of each frame
//     rgb_out      registered colour to the pins
//
//   Build option: define VGA_TEST_PATTERN_EN to add the pattern_sel input
//   and the built-in colour-bar generator.
// ----------------------------------------------------------------------------
module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CLK_DIV   = 4,   // system clocks per pixel, >= 2
    parameter int H_DISPLAY = vga_timing_gen_pkg::H_DISPLAY,
    parameter int H_FRONT   = vga_timing_gen_pkg::H_FRONT,
    parameter int H_BACK    = vga_timing_gen_pkg::H_BACK,
    parameter int H_RETRACE = vga_timing_gen_pkg::H_RETRACE,
    parameter int V_DISPLAY = vga_timing_gen_pkg::V_DISPLAY,
    parameter int V_FRONT   = vga_timing_gen_pkg::V_FRONT,
    parameter int V_BACK    = vga_timing_gen_pkg::V_BACK,
    parameter int V_RETRACE = vga_timing_gen_pkg::V_RETRACE
) (
    input  logic               clk,
    input  logic               reset,
`ifdef VGA_TEST_PATTERN_EN
    input  logic               pattern_sel,
`endif
    input  rgb_t               rgb_in,
    output logic               p_tick,
    output logic [COORD_W-1:0] pix_x,
    output logic [COORD_W-1:0] pix_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               frame_tick,
    output rgb_t               rgb_out
);

    localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_BACK + H_RETRACE;
    localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_BACK + V_RETRACE;
    localparam int DIV_W   = $clog2(CLK_DIV);

    localparam logic [COORD_W-1:0] H_VIS    = COORD_W'(H_DISPLAY);
    localparam logic [COORD_W-1:0] V_VIS    = COORD_W'(V_DISPLAY);
    localparam logic [COORD_W-1:0] HS_FIRST = COORD_W'(H_DISPLAY + H_FRONT);
    localparam logic [COORD_W-1:0] HS_LAST  = COORD_W'(H_DISPLAY + H_FRONT + H_RETRACE - 1);
    localparam logic [COORD_W-1:0] VS_FIRST = COORD_W'(V_DISPLAY + V_FRONT);
    localparam logic [COORD_W-1:0] VS_LAST  = COORD_W'(V_DISPLAY + V_FRONT + V_RETRACE - 1);

    logic [DIV_W-1:0]   div_count;
    logic [DIV_W-1:0]   div_count_next;
    logic               tick;
    logic [COORD_W-1:0] h_count;
    logic [COORD_W-1:0] h_next;
    logic               h_end;
    logic [COORD_W-1:0] v_count;
    logic [COORD_W-1:0] v_next;
    logic               v_end;
    logic               visible;

    logic hsync_q;
    logic hsync_d;
    logic vsync_q;
    logic vsync_d;
    rgb_t rgb_q;
    rgb_t rgb_d;
    rgb_t pixel_rgb;

    // ------------------------------------------------------------------
    // Counter chain: pixel divider -> column -> line.
    // ------------------------------------------------------------------
    mod_m_counter #(.M(CLK_DIV), .W(DIV_W)) u_pix_div (
        .clk          (clk),
        .reset        (reset),
        .en_i         (1'b1),
        .count_o      (div_count),
        .count_next_o (div_count_next),
        .max_tick_o   (tick)
    );

    mod_m_counter #(.M(H_TOTAL), .W(COORD_W)) u_h_count (
        .clk          (clk),
        .reset        (reset),
        .en_i         (tick),
        .count_o      (h_count),
        .count_next_o (h_next),
        .max_tick_o   (h_end)
    );

    mod_m_counter #(.M(V_TOTAL), .W(COORD_W)) u_v_count (
        .clk          (clk),
        .reset        (reset),
        .en_i         (tick & h_end),
        .count_o      (v_count),
        .count_next_o (v_next),
        .max_tick_o   (v_end)
    );

    // Only the divider's wrap pulse is needed; its count values are not.
    logic unused_div;
    assign unused_div = ^{div_count, div_count_next};

    // ------------------------------------------------------------------
    // Colour source: graphics layer, or the built-in bars when enabled.
    // ------------------------------------------------------------------
`ifdef VGA_TEST_PATTERN_EN
    localparam logic [COORD_W-1:0] BAR_W = COORD_W'(H_DISPLAY / 8);

    logic [COORD_W-1:0] bar_idx;
    logic               unused_bar_hi;

    // Only visible columns matter, so bar_idx never exceeds 7 where used.
    assign bar_idx       = h_count / BAR_W;
    assign unused_bar_hi = ^bar_idx[COORD_W-1:3];
    assign pixel_rgb     = pattern_sel ? bar_colour(bar_idx[2:0]) : rgb_in;
`else
    assign pixel_rgb = rgb_in;
`endif

    // ------------------------------------------------------------------
    // Syncs and colour register.
    // ------------------------------------------------------------------
    assign visible = (h_count < H_VIS) && (v_count < V_VIS);

    always_comb begin
        // Decoding the next counts lets the registered syncs change on the
        // same edge as pix_x/pix_y, with no skew between them.
        hsync_d = ((h_next >= HS_FIRST) && (h_next <= HS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        vsync_d = ((v_next >= VS_FIRST) && (v_next <= VS_LAST)) ? SYNC_ACTIVE : ~SYNC_ACTIVE;

        // Latch the colour of the pixel that is ending; blank outside the
        // visible area whatever the graphics layer returns.
        rgb_d = rgb_q;
        if (tick) begin
            rgb_d = visible ? pixel_rgb : RGB_BLACK;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync_q <= ~SYNC_ACTIVE;
            vsync_q <= ~SYNC_ACTIVE;
            rgb_q   <= RGB_BLACK;
        end else begin
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            rgb_q   <= rgb_d;
        end
    end

    assign p_tick     = tick;
    assign pix_x      = h_count;
    assign pix_y      = v_count;
    // Held low while reset is applied, even though the counts read (0,0).
    assign video_on   = visible & ~reset;
    assign hsync      = hsync_q;
    assign vsync      = vsync_q;
    assign frame_tick = tick & h_end & v_end;
    assign rgb_out    = rgb_q;

endmodule
